// File: rtl/ahb_pkg.sv
// ahb_pkg -- shared AHB encodings and helpers for the arbiter slice.
//   htrans_e / hburst_e / hresp_e : AMBA AHB field encodings
//   burst_beats()                 : beats remaining after the NONSEQ beat
//   onehot_idx()                  : index of the set bit in a one-hot vector
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'd0,
    TRANS_BUSY   = 2'd1,
    TRANS_NONSEQ = 2'd2,
    TRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'd0,
    RESP_ERROR = 2'd1,
    RESP_RETRY = 2'd2,
    RESP_SPLIT = 2'd3
  } hresp_e;

  // Undefined-length INCR and SINGLE give no burst boundary to protect,
  // so they load 0 and leave arbitration open every beat.
  function automatic logic [3:0] burst_beats(input logic [2:0] hb);
    case (hb)
      BURST_WRAP4,  BURST_INCR4:  return 4'd3;
      BURST_WRAP8,  BURST_INCR8:  return 4'd7;
      BURST_WRAP16, BURST_INCR16: return 4'd15;
      default:                    return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] onehot_idx(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (v[i]) r = r | 4'(i);
    return r;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// ahb_rr_picker -- combinational round-robin search.
//   req : request vector
//   ptr : last granted index; search starts at ptr+1 and visits ptr last
//   gnt : one-hot winner (all-zero when nobody requests)
//   vld : some request was found
import ahb_pkg::*;

module ahb_rr_picker #(
  parameter int N  = 3,
  parameter int PW = 4
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    int idx;
    idx = 0;
    gnt = '0;
    vld = 1'b0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!vld && req[IW'(idx)]) begin
        gnt[IW'(idx)] = 1'b1;
        vld           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_rr_arbiter_n.sv
// ahb_rr_arbiter_n -- N-master AHB round-robin arbiter with burst and lock hold.
//   HCLK, HRESET        : clock, async active-high reset
//   HBUSREQ, HLOCK      : per-master request / locked request
//   HTRANS, HBURST      : address-phase transfer and burst type
//   HREADY, HRESP       : bus ready, slave response
//   HGRANT              : one-hot grant, re-arbitrated only at safe points
//   HMASTER, HMASTLOCK  : address-phase owner and its lock, lagging HGRANT
import ahb_pkg::*;

module ahb_rr_arbiter_n #(
  parameter int NUM_MASTERS    = 3,
  parameter int DEFAULT_MASTER = 0,
  parameter int MASTER_BITS    = 4
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MASTER_BITS-1:0] HMASTER,
  output logic                   HMASTLOCK
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_n
    $fatal(1, "ahb_rr_arbiter_n: NUM_MASTERS must be 2..16");
  end
  if (DEFAULT_MASTER < 0 || DEFAULT_MASTER >= NUM_MASTERS) begin : g_bad_def
    $fatal(1, "ahb_rr_arbiter_n: DEFAULT_MASTER out of range");
  end
  if ((1 << MASTER_BITS) < NUM_MASTERS) begin : g_bad_mb
    $fatal(1, "ahb_rr_arbiter_n: MASTER_BITS too narrow");
  end

  localparam logic [NUM_MASTERS-1:0] DEF_GNT =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [MASTER_BITS-1:0] DEF_IDX = MASTER_BITS'(DEFAULT_MASTER);

  logic [3:0]             cnt, cnt_nxt;
  logic [MASTER_BITS-1:0] ptr, gidx, nidx;
  logic [NUM_MASTERS-1:0] pick_gnt, gnt_nxt;
  logic                   pick_vld, own_lock, arb_ok;

  // Beat counter: remaining beats of the fixed-length burst in flight.
  always_comb begin
    cnt_nxt = cnt;
    if (HRESP != RESP_OKAY) cnt_nxt = '0;
    else if (HREADY) begin
      case (HTRANS)
        TRANS_NONSEQ: cnt_nxt = burst_beats(HBURST);
        TRANS_SEQ:    cnt_nxt = (cnt != '0) ? cnt - 4'd1 : '0;
        TRANS_BUSY:   cnt_nxt = cnt;
        default:      cnt_nxt = '0;
      endcase
    end
  end

  ahb_rr_picker #(.N(NUM_MASTERS), .PW(MASTER_BITS)) u_pick (
    .req (HBUSREQ),
    .ptr (ptr),
    .gnt (pick_gnt),
    .vld (pick_vld)
  );

  always_comb begin
    gidx     = MASTER_BITS'(onehot_idx(16'(HGRANT)));
    own_lock = |(HLOCK & HGRANT);
    // Looking at the next-cycle count lets the grant move on the edge
    // that completes the last beat, not one cycle later.
    arb_ok   = HREADY && (cnt_nxt == '0) && !HMASTLOCK && !own_lock;
    gnt_nxt  = pick_vld ? pick_gnt : DEF_GNT;
    nidx     = MASTER_BITS'(onehot_idx(16'(gnt_nxt)));
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HGRANT    <= DEF_GNT;
      HMASTER   <= DEF_IDX;
      HMASTLOCK <= 1'b0;
      cnt       <= '0;
      ptr       <= DEF_IDX;
    end else begin
      cnt <= cnt_nxt;
      if (arb_ok) begin
        HGRANT <= gnt_nxt;
        ptr    <= nidx;
      end
      if (HREADY) begin
        HMASTER   <= gidx;
        HMASTLOCK <= own_lock;
      end
    end
  end

endmodule

// File: tb/tb_ahb_rr_arbiter_n.sv
module tb_ahb_rr_arbiter_n;

  localparam int N   = 4;
  localparam int DEF = 2;
  localparam int MB  = 4;

  logic          clk, rst;
  logic [N-1:0]  busreq, lock;
  logic [1:0]    trans, resp;
  logic [2:0]    burst;
  logic          ready;
  logic [N-1:0]  grant;
  logic [MB-1:0] master;
  logic          mlock;

  int n_chk = 0;
  int n_pass = 0;

  // Reference state: remaining beats, granted index, address-phase owner, lock.
  int m_cnt, m_gnt, m_mst;
  bit m_lock;

  ahb_rr_arbiter_n #(.NUM_MASTERS(N), .DEFAULT_MASTER(DEF), .MASTER_BITS(MB)) dut (
    .HCLK(clk), .HRESET(rst), .HBUSREQ(busreq), .HLOCK(lock),
    .HTRANS(trans), .HBURST(burst), .HREADY(ready), .HRESP(resp),
    .HGRANT(grant), .HMASTER(master), .HMASTLOCK(mlock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_gnt = DEF; m_mst = DEF; m_lock = 0;
  endtask

  // One clock: predict from the rules, clock, then compare all outputs.
  task automatic tick();
    int nc, ng, nm, c;
    bit nl, arb;
    nc = m_cnt; ng = m_gnt; nm = m_mst; nl = m_lock;
    if (resp != 2'd0) nc = 0;
    else if (ready) begin
      if (trans == 2'd2)      nc = (burst >= 3'd2) ? (1 << (int'(burst) / 2 + 1)) - 1 : 0;
      else if (trans == 2'd3) nc = (m_cnt > 0) ? m_cnt - 1 : 0;
      else if (trans == 2'd0) nc = 0;
    end
    arb = ready && nc == 0 && !m_lock && !lock[2'(m_gnt)];
    if (arb) begin
      ng = DEF;
      for (int k = 1; k <= N; k++) begin
        c = (m_gnt + k) % N;
        if (busreq[2'(c)]) begin ng = c; break; end
      end
    end
    if (ready) begin nm = m_gnt; nl = lock[2'(m_gnt)]; end
    @(posedge clk); #1;
    m_cnt = nc; m_gnt = ng; m_mst = nm; m_lock = nl;
    chk("hgrant",    32'(grant),  32'(1) << m_gnt);
    chk("hmaster",   32'(master), 32'(m_mst));
    chk("hmastlock", 32'(mlock),  32'(m_lock));
  endtask

  task automatic drive(input logic [N-1:0] rq, input logic [N-1:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu,
                       input logic rd, input logic [1:0] rs);
    busreq = rq; lock = lk; trans = tr; burst = bu; ready = rd; resp = rs;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      busreq = 4'($urandom);
      lock   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
      trans  = 2'($urandom);
      burst  = 3'($urandom);
      ready  = ($urandom_range(0, 4) != 0);
      resp   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0);
    model_reset();
    #12;
    chk("rst_grant",  32'(grant),  32'h4);
    chk("rst_master", 32'(master), 32'd2);
    chk("rst_lock",   32'(mlock),  32'd0);
    @(negedge clk); rst = 1'b0;

    // Parking with nobody requesting.
    repeat (3) tick();
    chk("park", 32'(grant), 32'h4);

    // Round-robin, everyone requesting SINGLE beats.
    for (int i = 0; i < N; i++) begin
      drive(4'b1111, 4'b0000, 2'd2, 3'd0, 1'b1, 2'd0);
      tick();
      chk("rr_seq", 32'(grant), 32'(1) << ((DEF + 1 + i) % N));
    end

    // Burst hold: M0 runs INCR4 while M1 requests.
    drive(4'b0001, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0); tick(); tick();
    drive(4'b0011, 4'b0000, 2'd2, 3'd3, 1'b1, 2'd0); tick();
    chk("incr4_nseq", 32'(grant), 32'h1);
    trans = 2'd3;
    tick(); chk("incr4_b2", 32'(grant), 32'h1);
    tick(); chk("incr4_b3", 32'(grant), 32'h1);
    tick(); chk("incr4_b4", 32'(grant), 32'h2);
    drive(4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0); tick();
    chk("incr4_hm", 32'(master), 32'd1);

    // Lock: M2 locked with everyone requesting.
    drive(4'b1111, 4'b0100, 2'd2, 3'd0, 1'b1, 2'd0); tick();
    chk("lock_gnt", 32'(grant), 32'h4);
    tick(); chk("lock_ml", 32'(mlock), 32'd1);
    repeat (3) tick();
    chk("lock_hold", 32'(grant), 32'h4);
    lock = 4'b0000; tick();
    chk("unlock_gnt", 32'(grant), 32'h4);
    chk("unlock_ml",  32'(mlock), 32'd0);
    tick(); chk("unlock_move", 32'(grant), 32'h8);

    // Wait states at the end of an M3 INCR4.
    drive(4'b1001, 4'b0000, 2'd2, 3'd3, 1'b1, 2'd0); tick();
    trans = 2'd3; tick(); tick();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ws_grant",  32'(grant),  32'h8);
      chk("ws_master", 32'(master), 32'd3);
      chk("ws_lock",   32'(mlock),  32'd0);
    end
    ready = 1'b1; tick();
    chk("ws_done", 32'(grant), 32'h1);

    // ERROR at beat 2 of an M0 INCR8 with M3 requesting.
    drive(4'b1001, 4'b0000, 2'd2, 3'd5, 1'b1, 2'd0); tick();
    trans = 2'd3; tick();
    ready = 1'b0; resp = 2'd1; tick();
    chk("err_hold", 32'(grant), 32'h1);
    ready = 1'b1; trans = 2'd0; tick();
    chk("err_move", 32'(grant), 32'h8);
    resp = 2'd0;

    rand_cycles(1500);

    // Reset in the middle of a locked INCR16.
    drive(4'b1111, 4'b1111, 2'd2, 3'd7, 1'b1, 2'd0); tick(); tick();
    trans = 2'd3; tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_grant",  32'(grant),  32'h4);
    chk("arst_master", 32'(master), 32'd2);
    chk("arst_lock",   32'(mlock),  32'd0);
    model_reset();
    @(posedge clk); #2 rst = 1'b0;
    drive(4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 2'd0); tick();
    chk("post_rst_park", 32'(grant), 32'h4);
    rand_cycles(300);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
